// File: rtl/prefetcher_pkg.sv
// prefetcher_pkg: shared types and constants for the prefetcher read path.
//   arReq_t    - one queued read-address request {addr, len, id} at default widths
//   rspState_e - read responder FSM states {IDLE, WAIT, BURST}
//   RESP_OKAY  - R-channel response code returned on every beat
//   data_bits  - beat width in bits from log2 of the beat width in bytes
package prefetcher_pkg;

  localparam int unsigned AR_ADDR_BITS = 64;
  localparam int unsigned AR_LEN_BITS  = 4;
  localparam int unsigned AR_ID_BITS   = 4;

  typedef struct packed {
    logic [AR_ADDR_BITS-1:0] addr;
    logic [AR_LEN_BITS-1:0]  len;
    logic [AR_ID_BITS-1:0]   id;
  } arReq_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } rspState_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int unsigned data_bits(input int unsigned log_bytes);
    return 32'd8 << log_bytes;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// req_fifo: synchronous in-order FIFO for queued read-address requests.
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_push, i_data      write request and payload (ignored when full)
//   i_pop               read request (ignored when empty); o_data shows the head entry
//   o_full, o_empty     status flags
//   o_count             number of stored entries (0 .. 2^LOG_DEPTH)
module req_fifo #(
  parameter int unsigned LOG_DEPTH = 2,
  parameter int unsigned WIDTH     = 72
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [LOG_DEPTH:0] o_count
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [LOG_DEPTH:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_full    = (r_count == (LOG_DEPTH+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (LOG_DEPTH+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (LOG_DEPTH+1)'(1);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ddr_read_responder.sv
// ddr_read_responder: DDR model answering prefetcher AR requests with INCR read bursts.
// Each beat carries its own (beat-aligned) byte address as data, so consumers can self-check.
// Optional feature macro: DDR_RESP_LATENCY_EN adds crs_latency and a WAIT state that delays
// the first beat of every burst by crs_latency cycles.
// Ports:
//   clk, resetN                clock (rising edge), asynchronous active-low reset
//   ar_valid/ar_ready          request handshake; ar_addr, ar_len (beats-1), ar_id
//   r_valid/r_ready            beat handshake; r_data, r_last, r_id, r_resp (always OKAY)
//   outstanding                queued requests plus the active burst
//   crs_latency                first-beat delay in cycles (DDR_RESP_LATENCY_EN only)
module ddr_read_responder import prefetcher_pkg::*; #(
  parameter int unsigned LOG_QUEUE_SIZE       = 2,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 3,
  parameter int unsigned ADDR_BITS            = AR_ADDR_BITS,
  parameter int unsigned BURST_LEN_WIDTH      = AR_LEN_BITS,
  parameter int unsigned ID_WIDTH             = AR_ID_BITS
`ifdef DDR_RESP_LATENCY_EN
  ,
  parameter int unsigned LATENCY_WIDTH        = 4
`endif
) (
  input  logic                                     clk,
  input  logic                                     resetN,
  input  logic                                     ar_valid,
  output logic                                     ar_ready,
  input  logic [ADDR_BITS-1:0]                     ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0]               ar_len,
  input  logic [ID_WIDTH-1:0]                      ar_id,
  output logic                                     r_valid,
  input  logic                                     r_ready,
  output logic [data_bits(LOG_BLOCK_DATA_BYTES)-1:0] r_data,
  output logic                                     r_last,
  output logic [ID_WIDTH-1:0]                      r_id,
  output logic [1:0]                               r_resp,
`ifdef DDR_RESP_LATENCY_EN
  input  logic [LATENCY_WIDTH-1:0]                 crs_latency,
`endif
  output logic [LOG_QUEUE_SIZE:0]                  outstanding
);

  localparam int unsigned DATA_BITS = data_bits(LOG_BLOCK_DATA_BYTES);
  localparam int unsigned REQ_BITS  = ADDR_BITS + BURST_LEN_WIDTH + ID_WIDTH;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_BURST = BURST;
`ifdef DDR_RESP_LATENCY_EN
  localparam logic [1:0] ST_WAIT  = WAIT;
`endif

  // Clears the in-beat byte offset of a start address.
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
    ~((ADDR_BITS'(1) << LOG_BLOCK_DATA_BYTES) - ADDR_BITS'(1));

  logic [1:0]                 r_state;
  logic [BURST_LEN_WIDTH-1:0] r_beat_cnt;
  logic [ADDR_BITS-1:0]       r_act_base;
  logic [BURST_LEN_WIDTH-1:0] r_act_len;
  logic [ID_WIDTH-1:0]        r_act_id;

  logic [1:0]                 w_state_nxt;
  logic [BURST_LEN_WIDTH-1:0] w_beat_cnt_nxt;
  logic [ADDR_BITS-1:0]       w_act_base_nxt;
  logic [BURST_LEN_WIDTH-1:0] w_act_len_nxt;
  logic [ID_WIDTH-1:0]        w_act_id_nxt;

`ifdef DDR_RESP_LATENCY_EN
  logic [LATENCY_WIDTH-1:0]   r_wait_cnt;
  logic [LATENCY_WIDTH-1:0]   w_wait_cnt_nxt;
`endif

  logic                       w_push;
  logic                       w_full;
  logic                       w_empty;
  logic [LOG_QUEUE_SIZE:0]    w_fifo_count;
  logic [REQ_BITS-1:0]        w_head;
  logic [ADDR_BITS-1:0]       w_head_addr;
  logic [BURST_LEN_WIDTH-1:0] w_head_len;
  logic [ID_WIDTH-1:0]        w_head_id;
  logic                       w_hs;
  logic                       w_last;
  logic                       w_load;
  logic [ADDR_BITS-1:0]       w_beat_addr;

  // No pass-through: a full queue refuses even when the head is popped this cycle.
  assign ar_ready = resetN && !w_full;
  assign w_push   = ar_valid && ar_ready;

  req_fifo #(
    .LOG_DEPTH (LOG_QUEUE_SIZE),
    .WIDTH     (REQ_BITS)
  ) u_req_fifo (
    .i_clk   (clk),
    .i_rst_n (resetN),
    .i_push  (w_push),
    .i_data  ({ar_addr, ar_len, ar_id}),
    .i_pop   (w_load),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign w_head_addr = w_head[REQ_BITS-1 -: ADDR_BITS];
  assign w_head_len  = w_head[ID_WIDTH +: BURST_LEN_WIDTH];
  assign w_head_id   = w_head[ID_WIDTH-1:0];

  assign w_last = (r_beat_cnt == r_act_len);
  assign w_hs   = (r_state == ST_BURST) && r_ready;
  // Load the next request from idle, or on the final handshake so bursts run without a bubble.
  assign w_load = !w_empty && ((r_state == ST_IDLE) || (w_hs && w_last));

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_act_base_nxt = r_act_base;
    w_act_len_nxt  = r_act_len;
    w_act_id_nxt   = r_act_id;
`ifdef DDR_RESP_LATENCY_EN
    w_wait_cnt_nxt = r_wait_cnt;
`endif
    if (w_load) begin
      w_beat_cnt_nxt = '0;
      w_act_base_nxt = w_head_addr & ALIGN_MASK;
      w_act_len_nxt  = w_head_len;
      w_act_id_nxt   = w_head_id;
`ifdef DDR_RESP_LATENCY_EN
      if (crs_latency != '0) begin
        w_state_nxt    = ST_WAIT;
        w_wait_cnt_nxt = crs_latency;
      end else begin
        w_state_nxt    = ST_BURST;
      end
`else
      w_state_nxt    = ST_BURST;
`endif
    end else begin
      case (r_state)
`ifdef DDR_RESP_LATENCY_EN
        ST_WAIT: begin
          if (r_wait_cnt <= LATENCY_WIDTH'(1)) w_state_nxt = ST_BURST;
          else w_wait_cnt_nxt = r_wait_cnt - LATENCY_WIDTH'(1);
        end
`endif
        ST_BURST: begin
          if (w_hs) begin
            if (w_last) w_state_nxt = ST_IDLE;
            else w_beat_cnt_nxt = r_beat_cnt + BURST_LEN_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_act_base <= '0;
      r_act_len  <= '0;
      r_act_id   <= '0;
`ifdef DDR_RESP_LATENCY_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_act_base <= w_act_base_nxt;
      r_act_len  <= w_act_len_nxt;
      r_act_id   <= w_act_id_nxt;
`ifdef DDR_RESP_LATENCY_EN
      r_wait_cnt <= w_wait_cnt_nxt;
`endif
    end
  end

  // Wraps modulo 2^ADDR_BITS at the top of the address space.
  assign w_beat_addr = r_act_base + (ADDR_BITS'(r_beat_cnt) << LOG_BLOCK_DATA_BYTES);

  assign r_valid     = (r_state == ST_BURST);
  assign r_last      = r_valid && w_last;
  assign r_data      = r_valid ? DATA_BITS'(w_beat_addr) : '0;
  assign r_id        = r_valid ? r_act_id : '0;
  assign r_resp      = RESP_OKAY;
  assign outstanding = w_fifo_count + (LOG_QUEUE_SIZE+1)'(r_state != ST_IDLE);

endmodule

// File: tb/tb_ddr_read_responder.sv
// Directed self-checking bench for ddr_read_responder (default parameters).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ddr_read_responder;

  logic        clk;
  logic        resetN;
  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [3:0]  ar_len;
  logic [3:0]  ar_id;
  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic        r_last;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic [2:0]  outstanding;
`ifdef DDR_RESP_LATENCY_EN
  logic [3:0]  crs_latency;
`endif

  int n_cmp;
  int n_fail;

  logic [63:0] cap_data [16];
  logic        cap_last [16];
  logic [3:0]  cap_id   [16];
  int          cap_n;
  int          cap_first;
  int          cap_end;
  int          peak_out;

  ddr_read_responder dut (
    .clk         (clk),
    .resetN      (resetN),
    .ar_valid    (ar_valid),
    .ar_ready    (ar_ready),
    .ar_addr     (ar_addr),
    .ar_len      (ar_len),
    .ar_id       (ar_id),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_data      (r_data),
    .r_last      (r_last),
    .r_id        (r_id),
    .r_resp      (r_resp),
`ifdef DDR_RESP_LATENCY_EN
    .crs_latency (crs_latency),
`endif
    .outstanding (outstanding)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns cycles waited before acceptance (-1 on timeout).
  task automatic send_ar(input logic [63:0] addr, input logic [3:0] len, input logic [3:0] id,
                         output int waited);
    bit done;
    done     = 1'b0;
    waited   = -1;
    ar_valid = 1'b1;
    ar_addr  = addr;
    ar_len   = len;
    ar_id    = id;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ar_ready) begin
        done   = 1'b1;
        waited = i;
      end
      @(posedge clk);
      #1;
    end
    ar_valid = 1'b0;
  endtask

  // Records every handshaken beat; cap_first/cap_end are the sample indices of first/last beat.
  task automatic collect(input int n, input int budget);
    cap_n     = 0;
    cap_first = -1;
    cap_end   = -1;
    peak_out  = 0;
    for (int c = 0; c < budget && cap_n < n; c++) begin
      @(negedge clk);
      if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
      if (r_valid && r_ready) begin
        cap_data[cap_n] = r_data;
        cap_last[cap_n] = r_last;
        cap_id[cap_n]   = r_id;
        if (cap_n == 0) cap_first = c;
        cap_end = c;
        cap_n++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN   = 1'b0;
    ar_valid = 1'b0;
    ar_addr  = '0;
    ar_len   = '0;
    ar_id    = '0;
    r_ready  = 1'b0;
`ifdef DDR_RESP_LATENCY_EN
    crs_latency = '0;
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ar_ready, r_valid, r_last} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got ar_ready/r_valid/r_last=%b required 000",
               {ar_ready, r_valid, r_last});
    end
    n_cmp++;
    if (r_data !== 64'h0 || r_id !== 4'h0 || r_resp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h id=%h resp=%b required 0/0/0", r_data, r_id, r_resp);
    end
    n_cmp++;
    if (outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outstanding: got %0d required 0", outstanding);
    end
    #2 resetN = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ar_ready: got %b required 1", ar_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_burst();
    int w;
    logic [63:0] exp_d [3];
    exp_d[0] = 64'hdeadbef0;
    exp_d[1] = 64'hdeadbef8;
    exp_d[2] = 64'hdeadbf00;
    r_ready = 1'b1;
    fork
      send_ar(64'hdeadbef0, 4'd2, 4'd3, w);
      collect(3, 20);
    join
    n_cmp++;
    if (cap_n !== 3) begin
      n_fail++;
      $display("FAIL single_beats: got %0d beats required 3", cap_n);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (cap_data[i] !== exp_d[i] || cap_last[i] !== (i == 2) || cap_id[i] !== 4'd3) begin
        n_fail++;
        $display("FAIL single_beat%0d: got data=%h last=%b id=%h required %h/%b/3",
                 i, cap_data[i], cap_last[i], cap_id[i], exp_d[i], (i == 2));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (r_valid !== 1'b0 || r_resp !== 2'b00 || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL single_idle: got valid=%b resp=%b outst=%0d required 0/00/0",
               r_valid, r_resp, outstanding);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int w [4];
    r_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send_ar(64'(i + 1) << 8, 4'd1, 4'(i + 1), w[i]);
      end
      collect(8, 40);
    join
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (w[i] !== 0) begin
        n_fail++;
        $display("FAIL b2b_ar_ready%0d: got wait=%0d cycles required 0", i, w[i]);
      end
    end
    n_cmp++;
    if (cap_n !== 8 || (cap_end - cap_first) !== 7) begin
      n_fail++;
      $display("FAIL b2b_no_gap: got %0d beats over span %0d required 8 over 7",
               cap_n, cap_end - cap_first);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cap_data[i] !== ((64'(i / 2 + 1) << 8) + 64'((i % 2) * 8)) ||
          cap_last[i] !== (i % 2 == 1) || cap_id[i] !== 4'(i / 2 + 1)) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got data=%h last=%b id=%h", i, cap_data[i], cap_last[i],
                 cap_id[i]);
      end
    end
    // One request is already active and popped while the later ones arrive, so the peak is 3.
    n_cmp++;
    if (peak_out !== 3) begin
      n_fail++;
      $display("FAIL b2b_peak_outstanding: got %0d required 3", peak_out);
    end
    @(negedge clk);
    n_cmp++;
    if (outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_drained: got outstanding %0d required 0", outstanding);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int w;
    int unstable;
    r_ready = 1'b0;
    // One burst goes active and four more fill the queue.
    for (int i = 1; i <= 5; i++) begin
      send_ar(64'(i) << 12, 4'd1, 4'(i), w);
      n_cmp++;
      if (w !== 0) begin
        n_fail++;
        $display("FAIL bp_accept%0d: got wait=%0d required 0", i, w);
      end
    end
    ar_valid = 1'b1;
    ar_addr  = 64'h6000;
    ar_len   = 4'd0;
    ar_id    = 4'd6;
    @(negedge clk);
    n_cmp++;
    if (ar_ready !== 1'b0 || outstanding !== 3'd5 || r_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: got ar_ready=%b outst=%0d r_valid=%b required 0/5/1",
               ar_ready, outstanding, r_valid);
    end
    unstable = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (r_valid !== 1'b1 || r_data !== 64'h1000 || r_last !== 1'b0 || ar_ready !== 1'b0)
        unstable++;
    end
    n_cmp++;
    if (unstable !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d unstable cycles required 0", unstable);
    end
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
    r_ready  = 1'b1;
    collect(10, 60);
    n_cmp++;
    if (cap_n !== 10) begin
      n_fail++;
      $display("FAIL bp_drain_count: got %0d beats required 10", cap_n);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (cap_data[i] !== ((64'(i / 2 + 1) << 12) + 64'((i % 2) * 8)) ||
          cap_last[i] !== (i % 2 == 1) || cap_id[i] !== 4'(i / 2 + 1)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got data=%h last=%b id=%h", i, cap_data[i], cap_last[i],
                 cap_id[i]);
      end
    end
  endtask

  task automatic test_toggle_ready();
    int w;
    int n;
    logic [63:0] d [4];
    logic        l [4];
    r_ready = 1'b0;
    n = 0;
    fork
      send_ar(64'h0, 4'd3, 4'd5, w);
      begin
        for (int c = 0; c < 60 && n < 4; c++) begin
          @(negedge clk);
          if (r_valid && r_ready) begin
            d[n] = r_data;
            l[n] = r_last;
            n++;
          end
          @(posedge clk);
          #1;
          r_ready = ~r_ready;
        end
      end
    join
    r_ready = 1'b1;
    n_cmp++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d beats required 4", n);
    end
    for (int i = 0; i < 4 && i < n; i++) begin
      n_cmp++;
      if (d[i] !== 64'(i * 8) || l[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL toggle_beat%0d: got data=%h last=%b required %h/%b",
                 i, d[i], l[i], 64'(i * 8), (i == 3));
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_wrap_and_reset();
    int w;
    int c;
    r_ready = 1'b0;
    send_ar(64'hffff_ffff_ffff_fff8, 4'd1, 4'd9, w);
    c = 0;
    @(negedge clk);
    while (!r_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (r_valid !== 1'b1 || r_data !== 64'hffff_ffff_ffff_fff8 || r_last !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_beat0: got valid=%b data=%h last=%b required 1/fff..ff8/0",
               r_valid, r_data, r_last);
    end
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r_valid !== 1'b1 || r_data !== 64'h0 || r_last !== 1'b1 || outstanding !== 3'd1) begin
      n_fail++;
      $display("FAIL wrap_beat1: got valid=%b data=%h last=%b outst=%0d required 1/0/1/1",
               r_valid, r_data, r_last, outstanding);
    end
    #1 resetN = 1'b0;
    #1;
    n_cmp++;
    if (r_valid !== 1'b0 || outstanding !== 3'd0 || ar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midburst_reset: got valid=%b outst=%0d ar_ready=%b required 0/0/0",
               r_valid, outstanding, ar_ready);
    end
    #1 resetN = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    fork
      send_ar(64'h45, 4'd0, 4'd7, w);
      collect(1, 20);
    join
    n_cmp++;
    if (cap_n !== 1 || cap_data[0] !== 64'h40 || cap_last[0] !== 1'b1 || cap_id[0] !== 4'd7) begin
      n_fail++;
      $display("FAIL post_reset_burst: got n=%0d data=%h last=%b id=%h required 1/40/1/7",
               cap_n, cap_data[0], cap_last[0], cap_id[0]);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef DDR_RESP_LATENCY_EN
  task automatic test_latency();
    logic trace [10];
    logic exp_t [10];
    for (int k = 0; k < 10; k++) exp_t[k] = 1'b0;
    exp_t[4] = 1'b1;
    exp_t[8] = 1'b1;
    crs_latency = 4'd3;
    r_ready     = 1'b1;
    ar_valid    = 1'b1;
    ar_addr     = 64'h80;
    ar_len      = 4'd0;
    ar_id       = 4'd1;
    @(posedge clk);
    #1;
    ar_addr = 64'h88;
    ar_id   = 4'd2;
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      trace[k] = r_valid;
      @(posedge clk);
      #1;
    end
    for (int k = 1; k < 10; k++) begin
      n_cmp++;
      if (trace[k] !== exp_t[k]) begin
        n_fail++;
        $display("FAIL latency_trace%0d: got r_valid=%b required %b", k, trace[k], exp_t[k]);
      end
    end
    crs_latency = 4'd0;
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_backpressure();
    test_toggle_ready();
    test_wrap_and_reset();
`ifdef DDR_RESP_LATENCY_EN
    test_latency();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
